// File: rtl/fram_uart_pkg.sv
// Opcodes, ASCII constants and state encodings shared by the FRAM read and
// write paths.
package fram_uart_pkg;

   localparam logic [7:0] FRAM_OP_WREN  = 8'h06;
   localparam logic [7:0] FRAM_OP_WRITE = 8'h02;
   localparam logic [7:0] FRAM_OP_READ  = 8'h03;
   localparam logic [7:0] ASCII_NL      = 8'h0A;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WREN,
      ST_CS_GAP,
      ST_CMD,
      ST_WAIT_RX,
      ST_SPI_WRITE,
      ST_DONE
   } lr_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle valid
// pulse with a frame-error flag when the stop bit reads low.
module uart_rx_byte
   import fram_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       start_det
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

   rx_state_t     r_state, w_next;
   logic [1:0]    r_sync;
   logic          r_rx_prev;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_data;
   logic          r_valid;
   logic          r_ferr;

   logic w_rx, w_fall, w_sample_start, w_sample_bit;

   assign w_rx           = r_sync[1];
   assign w_fall         = r_rx_prev & ~w_rx;
   assign w_sample_start = (r_cnt == HALF_M1);
   assign w_sample_bit   = (r_cnt == LAST);

   always_comb begin
      // NOTE: every branch starts from the held state, so no path leaves w_next unassigned and no latch is inferred.
      w_next = r_state;
      case (r_state)
         RX_IDLE:  if (w_fall) w_next = RX_START;
         RX_START: if (w_sample_start) w_next = w_rx ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_sample_bit && (r_bit == 3'd7)) w_next = RX_STOP;
         RX_STOP:  if (w_sample_bit) w_next = RX_IDLE;
         default:  w_next = RX_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= RX_IDLE;
         r_sync    <= 2'b11;
         r_rx_prev <= 1'b1;
      end else begin
         r_state   <= w_next;
         r_sync    <= {r_sync[0], rx};
         r_rx_prev <= w_rx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_bit   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            RX_IDLE: begin
               r_cnt <= '0;
               r_bit <= '0;
            end
            RX_START: r_cnt <= w_sample_start ? '0 : r_cnt + CW'(1);
            RX_DATA: begin
               if (w_sample_bit) begin
                  r_cnt  <= '0;
                  r_data <= {w_rx, r_data[7:1]};
                  r_bit  <= r_bit + 3'd1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            RX_STOP: begin
               if (w_sample_bit) begin
                  r_cnt   <= '0;
                  r_valid <= 1'b1;
                  r_ferr  <= ~w_rx;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   assign data      = r_data;
   assign valid     = r_valid;
   assign frame_err = r_ferr;
   assign start_det = (r_state == RX_IDLE) & w_fall;

endmodule

// File: rtl/listen_and_remember.sv
// UART RX to SPI FRAM writer: WREN, WRITE+address, then one SPI byte per
// received character until newline or num_bytes. Define LISTEN_TIMEOUT_EN
// to abort after TIMEOUT_CLKS idle cycles between bytes.
module listen_and_remember
   import fram_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int TIMEOUT_CLKS = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] address,
   input  logic [5:0]  num_bytes,
   input  logic        uart_rx,
   input  logic        spi_miso,
   output logic        spi_clk,
   output logic        spi_mosi,
   output logic        spi_cs,
   output logic [5:0]  bytes_written,
   output logic        frame_err,
   output logic        done
);

   lr_state_t   r_state, w_next;
   logic [15:0] r_addr;
   logic [5:0]  r_num;
   logic [5:0]  r_bytes_written;
   logic [7:0]  r_sh;
   logic [3:0]  r_phase;
   logic [1:0]  r_byte_idx;
   logic        r_spi_cs, r_frame_err, r_done;

   logic [7:0]  w_rx_data;
   logic        w_rx_valid, w_rx_ferr, w_rx_start_det;
   logic        w_byte_end, w_last_write, w_rx_accept, w_timeout;
   logic        w_unused_miso;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (uart_rx),
      .data      (w_rx_data),
      .valid     (w_rx_valid),
      .frame_err (w_rx_ferr),
      .start_det (w_rx_start_det)
   );

   assign w_unused_miso = spi_miso;
   assign w_byte_end    = (r_phase == 4'd15);
   assign w_last_write  = (r_num != 6'd0) && ((r_bytes_written + 6'd1) == r_num);
   assign w_rx_accept   = (r_state == ST_WAIT_RX) && w_rx_valid && !w_rx_ferr
                          && (w_rx_data != ASCII_NL);

`ifdef LISTEN_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CLKS + 1);
   logic [TW-1:0] r_idle_cnt;

   // Idle time is measured from the last start bit, including the write that follows it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idle_cnt <= '0;
      end else if (w_rx_start_det || !(r_state inside {ST_WAIT_RX, ST_SPI_WRITE})) begin
         r_idle_cnt <= '0;
      end else if (!w_timeout) begin
         r_idle_cnt <= r_idle_cnt + TW'(1);
      end
   end

   assign w_timeout = (r_idle_cnt == TW'(TIMEOUT_CLKS - 1));
`else
   logic [32:0] w_unused_cfg;
   assign w_unused_cfg = {w_rx_start_det, 32'(TIMEOUT_CLKS)};
   assign w_timeout    = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    if (start) w_next = ST_WREN;
         ST_WREN:    if (w_byte_end) w_next = ST_CS_GAP;
         ST_CS_GAP:  if (r_byte_idx == 2'd1) w_next = ST_CMD;
         ST_CMD:     if (w_byte_end && (r_byte_idx == 2'd2)) w_next = ST_WAIT_RX;
         ST_WAIT_RX: begin
            if (w_rx_valid) begin
               if (w_rx_ferr)                   w_next = ST_WAIT_RX;
               else if (w_rx_data == ASCII_NL) w_next = ST_DONE;
               else                             w_next = ST_SPI_WRITE;
            end else if (w_timeout) begin
               w_next = ST_DONE;
            end
         end
         ST_SPI_WRITE: if (w_byte_end) w_next = w_last_write ? ST_DONE : ST_WAIT_RX;
         ST_DONE:      if (!start) w_next = ST_IDLE;
         default:      w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // SPI engine: r_phase[0] is spi_clk; the shifter advances after each high phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr          <= '0;
         r_num           <= '0;
         r_bytes_written <= '0;
         r_sh            <= '0;
         r_phase         <= '0;
         r_byte_idx      <= '0;
         r_spi_cs        <= 1'b1;
         r_frame_err     <= 1'b0;
         r_done          <= 1'b0;
      end else begin
         r_spi_cs <= !(w_next inside {ST_WREN, ST_CMD, ST_WAIT_RX, ST_SPI_WRITE});
         r_done   <= (w_next == ST_DONE);
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_addr          <= address;
                  r_num           <= num_bytes;
                  r_bytes_written <= '0;
                  r_frame_err     <= 1'b0;
                  r_sh            <= FRAM_OP_WREN;
                  r_phase         <= '0;
                  r_byte_idx      <= '0;
               end
            end
            ST_WREN, ST_CMD, ST_SPI_WRITE: begin
               r_phase <= r_phase + 4'd1;
               if (r_phase[0]) r_sh <= {r_sh[6:0], 1'b0};
               if (w_byte_end) begin
                  r_byte_idx <= r_byte_idx + 2'd1;
                  if (r_state == ST_WREN) r_byte_idx <= '0;
                  if (r_state == ST_CMD && r_byte_idx == 2'd0) r_sh <= r_addr[15:8];
                  if (r_state == ST_CMD && r_byte_idx == 2'd1) r_sh <= r_addr[7:0];
                  if (r_state == ST_SPI_WRITE) r_bytes_written <= r_bytes_written + 6'd1;
               end
            end
            ST_CS_GAP: begin
               r_byte_idx <= r_byte_idx + 2'd1;
               if (r_byte_idx == 2'd1) begin
                  r_sh       <= FRAM_OP_WRITE;
                  r_byte_idx <= '0;
               end
            end
            ST_WAIT_RX: begin
               if (w_rx_valid && w_rx_ferr) r_frame_err <= 1'b1;
               if (w_rx_accept) r_sh <= w_rx_data;
            end
            default: ;
         endcase
      end
   end

   assign spi_clk       = r_phase[0];
   assign spi_mosi      = r_sh[7];
   assign spi_cs        = r_spi_cs;
   assign bytes_written = r_bytes_written;
   assign frame_err     = r_frame_err;
   assign done          = r_done;

endmodule

// File: tb/tb_listen_and_remember.sv
// Directed self-checking bench for listen_and_remember (CLKS_PER_BIT=4,
// TIMEOUT_CLKS=64); timeout expectations follow LISTEN_TIMEOUT_EN.
module tb_listen_and_remember;

   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] address;
   logic [5:0]  num_bytes;
   logic        uart_rx;
   logic        spi_miso;
   logic        spi_clk, spi_mosi, spi_cs;
   logic [5:0]  bytes_written;
   logic        frame_err, done;

   int n_vec  = 0;
   int n_miss = 0;

   logic [7:0] cap[$];
   logic [7:0] exp_q[$];
   logic [7:0] mon_sh;
   int         mon_bits;
   logic       mon_prev_sclk;
   int         hi_run;
   int         cs_gap_len;
   int         sclk_rises;

   listen_and_remember #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(64)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .address       (address),
      .num_bytes     (num_bytes),
      .uart_rx       (uart_rx),
      .spi_miso      (spi_miso),
      .spi_clk       (spi_clk),
      .spi_mosi      (spi_mosi),
      .spi_cs        (spi_cs),
      .bytes_written (bytes_written),
      .frame_err     (frame_err),
      .done          (done)
   );

   always #5 clk = ~clk;

   // SPI slave model: sample MOSI on each rising spi_clk while selected.
   initial begin
      mon_sh = '0; mon_bits = 0; mon_prev_sclk = 1'b0;
      hi_run = 0; cs_gap_len = 0; sclk_rises = 0;
   end

   always @(negedge clk) begin
      if (!rst_n || spi_cs) begin
         mon_bits <= 0;
      end else if (spi_clk && !mon_prev_sclk) begin
         sclk_rises <= sclk_rises + 1;
         mon_sh     <= {mon_sh[6:0], spi_mosi};
         if (mon_bits == 7) begin
            cap.push_back({mon_sh[6:0], spi_mosi});
            mon_bits <= 0;
         end else begin
            mon_bits <= mon_bits + 1;
         end
      end
      mon_prev_sclk <= spi_clk;
      if (spi_cs) begin
         hi_run <= hi_run + 1;
      end else begin
         if (hi_run != 0) cs_gap_len <= hi_run;
         hi_run <= 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_stream(input string tag, input int base);
      check({tag, " len"}, cap.size() - base, exp_q.size());
      foreach (exp_q[i])
         check($sformatf("%s b%0d", tag, i),
               (base + i < cap.size()) ? {24'h0, cap[base + i]} : 32'hDEAD_BEEF,
               {24'h0, exp_q[i]});
   endtask

   task automatic uart_send(input logic [7:0] b, input logic stop_bit);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stop_bit;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic wait_done(input string tag, input int budget);
      for (int i = 0; i < budget && !done; i++) @(negedge clk);
      check({tag, " done"}, done, 1);
   endtask

   task automatic begin_xfer(input logic [15:0] a, input logic [5:0] n);
      address   = a;
      num_bytes = n;
      start     = 1'b1;
      repeat (80) @(negedge clk);
   endtask

   task automatic end_xfer(input string tag);
      start = 1'b0;
      @(negedge clk);
      check({tag, " done clr"}, done, 0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst_n = 1'b0; start = 1'b0; address = '0; num_bytes = '0;
      uart_rx = 1'b1; spi_miso = 1'b0;
      repeat (3) @(negedge clk);
      check("rst spi_cs", spi_cs, 1);
      check("rst spi_clk", spi_clk, 0);
      check("rst spi_mosi", spi_mosi, 0);
      check("rst bytes_written", bytes_written, 0);
      check("rst frame_err", frame_err, 0);
      check("rst done", done, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // "AB\n" with no byte limit
      base = cap.size();
      begin_xfer(16'h1234, 6'd0);
      check("t1 cs low in wait", spi_cs, 0);
      uart_send(8'h41, 1'b1);
      uart_send(8'h42, 1'b1);
      uart_send(8'h0A, 1'b1);
      wait_done("t1", 200);
      check("t1 spi_cs", spi_cs, 1);
      check("t1 bytes_written", bytes_written, 2);
      check("t1 frame_err", frame_err, 0);
      check("t1 cs gap", cs_gap_len, 2);
      exp_q = '{8'h06, 8'h02, 8'h12, 8'h34, 8'h41, 8'h42};
      check_stream("t1 mosi", base);
      end_xfer("t1");

      // byte limit of 3: "WXYZ", Z lands in DONE
      base = cap.size();
      begin_xfer(16'h00FF, 6'd3);
      uart_send(8'h57, 1'b1);
      uart_send(8'h58, 1'b1);
      uart_send(8'h59, 1'b1);
      check("t2 bw after Y", bytes_written, 2);
      check("t2 not done during 3rd write", done, 0);
      uart_send(8'h5A, 1'b1);
      wait_done("t2", 50);
      check("t2 bytes_written", bytes_written, 3);
      check("t2 spi_cs", spi_cs, 1);
      exp_q = '{8'h06, 8'h02, 8'h00, 8'hFF, 8'h57, 8'h58, 8'h59};
      check_stream("t2 mosi", base);
      end_xfer("t2");

      // bad stop bit on 0x55, then "C\n"
      base = cap.size();
      begin_xfer(16'hA5C3, 6'd0);
      uart_send(8'h55, 1'b0);
      check("t3 frame_err set", frame_err, 1);
      check("t3 bw after bad byte", bytes_written, 0);
      uart_send(8'h43, 1'b1);
      uart_send(8'h0A, 1'b1);
      wait_done("t3", 200);
      check("t3 frame_err sticky", frame_err, 1);
      check("t3 bytes_written", bytes_written, 1);
      exp_q = '{8'h06, 8'h02, 8'hA5, 8'hC3, 8'h43};
      check_stream("t3 mosi", base);
      end_xfer("t3");

      // 1-clk glitch in WAIT_RX, then newline still accepted
      base = cap.size();
      begin_xfer(16'h0000, 6'd0);
      check("t4 frame_err cleared", frame_err, 0);
      begin
         int rises0;
         rises0 = sclk_rises;
         uart_rx = 1'b0;
         @(negedge clk);
         uart_rx = 1'b1;
         repeat (40) @(negedge clk);
         check("t4 no sclk after glitch", sclk_rises - rises0, 0);
      end
      check("t4 cs still low", spi_cs, 0);
      check("t4 done", done, 0);
      check("t4 bytes_written", bytes_written, 0);
      check("t4 no extra byte", cap.size() - base, 4);
      uart_send(8'h0A, 1'b1);
      wait_done("t4", 200);
      check("t4 bw after nl", bytes_written, 0);
      end_xfer("t4");

      // reset 20 clk into CMD, then a clean restart
      address = 16'hBEEF; num_bytes = 6'd1; start = 1'b1;
      repeat (39) @(negedge clk);
      check("t5 in cmd cs low", spi_cs, 0);
      rst_n = 1'b0;
      #1;
      check("t5 rst spi_cs", spi_cs, 1);
      check("t5 rst spi_clk", spi_clk, 0);
      check("t5 rst spi_mosi", spi_mosi, 0);
      check("t5 rst bytes_written", bytes_written, 0);
      check("t5 rst frame_err", frame_err, 0);
      check("t5 rst done", done, 0);
      repeat (2) @(negedge clk);
      base = cap.size();
      rst_n = 1'b1;
      repeat (80) @(negedge clk);
      uart_send(8'h6B, 1'b1);
      wait_done("t5", 50);
      check("t5 bytes_written", bytes_written, 1);
      exp_q = '{8'h06, 8'h02, 8'hBE, 8'hEF, 8'h6B};
      check_stream("t5 mosi", base);
      end_xfer("t5");

      // "Q" then silence
      base = cap.size();
      begin_xfer(16'h0100, 6'd0);
      uart_send(8'h51, 1'b1);
      repeat (16) @(negedge clk);
      check("t6 bw after Q", bytes_written, 1);
      check("t6 not done yet", done, 0);
      repeat (12) @(negedge clk);
`ifdef LISTEN_TIMEOUT_EN
      check("t6 timeout done", done, 1);
      check("t6 timeout cs", spi_cs, 1);
`else
      check("t6 no timeout", done, 0);
      repeat (150) @(negedge clk);
      check("t6 still waiting", done, 0);
      check("t6 cs still low", spi_cs, 0);
      uart_send(8'h0A, 1'b1);
      wait_done("t6", 50);
`endif
      check("t6 bw final", bytes_written, 1);
      exp_q = '{8'h06, 8'h02, 8'h01, 8'h00, 8'h51};
      check_stream("t6 mosi", base);
      end_xfer("t6");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/listen_and_remember.md
Name: listen_and_remember

Overview:
- Receive-side counterpart of the FRAM read-and-talk path.
- Captures 8N1 bytes arriving on a UART RX line and writes them sequentially into the SPI FRAM, starting at a given 16-bit address.
- A transfer ends on newline (0x0A, not stored) or when num_bytes data bytes have been written.
- Sits between the external UART pin and the shared FRAM SPI bus.

Parameters:
- CLKS_PER_BIT, 4, clk cycles per UART bit; must be ≥2. Sampling happens at cycle CLKS_PER_BIT/2 of each bit.
- TIMEOUT_CLKS, 4096, idle clk cycles between bytes before abort. Used only with LISTEN_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  level; a transfer begins on IDLE with start=1
- address  in  16  FRAM start address, latched at start
- num_bytes  in  6  maximum data bytes to store; 0 means stop only on newline (or timeout)
- uart_rx  in  1  UART RX line, idle high; 2-flop synchronised internally
- spi_miso  in  1  unused; present for bus symmetry
- spi_clk  out  1  FRAM SPI clock, mode 0
- spi_mosi  out  1  FRAM SPI MOSI, MSB first
- spi_cs  out  1  FRAM chip select, active low
- bytes_written  out  6  data bytes committed to FRAM in the current/last transfer
- frame_err  out  1  sticky; set on a bad stop bit, cleared at next start
- done  out  1  high in DONE until start is deasserted

Behaviour:
- Reset values: spi_clk=0, spi_mosi=0, spi_cs=1, bytes_written=0, frame_err=0, done=0. State=IDLE; RX sampler idle.
- Reset mid-transfer aborts immediately: spi_cs goes to 1 asynchronously; no partial byte is completed.
- SPI byte engine:
  - spi_clk toggles every clk while shifting, so one byte takes 16 clk cycles.
  - MOSI updates while spi_clk is low; the FRAM samples on the rising edge.
  - spi_clk returns to 0 at byte end.
- States:
  - IDLE: spi_cs=1, done=0. On start: latch address and num_bytes, clear bytes_written and frame_err, go to WREN.
  - WREN: spi_cs=0, shift 0x06, then go to CS_GAP.
  - CS_GAP: spi_cs=1 for exactly 2 clk cycles, then go to CMD.
  - CMD: spi_cs=0, shift 0x02, addr[15:8], addr[7:0] back-to-back (48 clk cycles), then go to WAIT_RX. spi_cs stays low from here.
  - WAIT_RX: waits for rx_valid from the RX sampler.
    - Byte 0x0A, or any byte with frame error: not written.
    - 0x0A goes to DONE.
    - A framing-error byte sets frame_err and stays in WAIT_RX.
    - Any other byte goes to SPI_WRITE.
  - SPI_WRITE: shift the byte and increment bytes_written. If num_bytes≠0 and bytes_written==num_bytes, go to DONE; otherwise go to WAIT_RX.
  - DONE: spi_cs=1, done=1. When start=0, go to IDLE.
- RX sampler:
  - Start is detected on a falling edge of the synced line; the start bit is re-checked low at mid-bit, otherwise it is a glitch and ignored.
  - Samples 8 data bits LSB first, then the stop bit.
  - rx_valid is a 1-cycle pulse at the stop-bit sample point.
  - The sampler runs in every state, but bytes are consumed only in WAIT_RX. A byte completing in any other state is dropped. Senders must wait for the command phase (≈70 clk).
- A byte that completes during SPI_WRITE is lost. The 16-clk write is always shorter than a UART frame (≥20 clk), so this cannot happen at legal rates.
- FRAM address wrap (0xFFFF→0x0000) is handled by the FRAM; the block counts only bytes.

Optional Feature:
- LISTEN_TIMEOUT_EN defined: in WAIT_RX, a counter resets on each rx start-bit detect. At TIMEOUT_CLKS idle cycles, go to DONE with bytes_written unchanged.
- Undefined: WAIT_RX waits indefinitely; no counter is synthesised.

Decomposition:
- Package fram_uart_pkg holds:
  - FRAM_OP_WREN=8'h06, FRAM_OP_WRITE=8'h02, FRAM_OP_READ=8'h03, ASCII_NL=8'h0A
  - the state encoding
- These constants are shared with the read path.
- One sub-module, uart_rx_byte:
  - parameter CLKS_PER_BIT
  - ports: clk, rst_n, rx, data[7:0], valid, frame_err
  - contains the synchroniser and sampler.

Test Plan:
- address=0x1234, num_bytes=0, send "AB\n": MOSI stream 06 | CS gap | 02 12 34 41 42, spi_cs then high, done=1, bytes_written=2.
- num_bytes=3, send "WXYZ": bytes 57 58 59 written, done after third write, 'Z' ignored, bytes_written=3.
- Send 0x55 with stop bit 0, then "C\n": frame_err=1, only 0x43 written, bytes_written=1.
- 1-clk low glitch on uart_rx while in WAIT_RX: no byte accepted, no SPI activity, state unchanged.
- Assert rst_n low during CMD after 20 clk: spi_cs=1 and all outputs at reset values in the same cycle. Restart succeeds from WREN.
- With LISTEN_TIMEOUT_EN and TIMEOUT_CLKS=64, send "Q" then silence: 0x51 written, done=1 64 clk after the last start-bit detect. Without the macro, done stays 0.
